alt_vipitc131_is2vid_mode_sequencer: RTL and testbench
======================================================

# alt_vipitc131_is2vid_mode_sequencer

Multi-mode timing-parameter calculator for the IS2Vid clocked-video output path. It holds `NUM_MODES` raw video-mode descriptors in a register bank and derives the counter-compare values for a requested mode over a fixed 3-stage sequenced datapath. It stages the result in a shadow set and commits it to the active outputs only at a frame boundary, so the timing generator never sees a torn mode.

## Interface
- `NUM_MODES`, 4: number of stored modes; power of two, ≥2.
- `WIDTH`, 16: width of raw fields and derived outputs.
- `LINE_WIDTH`, 13: width of `total_line_count_f0`; must be ≤ `WIDTH`.
- `MODE_W`, $clog2(NUM_MODES): mode index width (derived, not overridden).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  bank write strobe.
- `wr_mode`  in  MODE_W  mode written.
- `wr_field`  in  4  field index: 0 sample_count_f0, 1 line_count_f0, 2 line_count_f1, 3 h_front_porch, 4 h_sync_length, 5 h_blank, 6 v_front_porch, 7 v_blank, 8 v1_front_porch, 9 v1_blank, 10 ap_line, 11 v1_rising_edge, 12 interlaced (bit 0); 13–15 ignored.
- `wr_data`  in  WIDTH  write data.
- `calc_req`  in  1  request calculation of `calc_mode`.
- `calc_mode`  in  MODE_W  mode to calculate.
- `calc_ready`  out  1  high only in IDLE; request accepted when `calc_req & calc_ready`.
- `frame_start`  in  1  single-cycle frame-boundary strobe from the timing generator.
- `mode_changed`  out  1  one-cycle pulse when active outputs update.
- `calc_error`  out  1  sticky range-check error (see Configuration).
- `interlaced`  out  1  active interlaced flag.
- `h_total_minus_one`, `v_total_minus_one`, `h_sync_start`, `h_sync_end`, `ap_line_end`, `f1_v_start`, `f1_v_end`, `f2_v_start`  out  WIDTH  active derived values.
- `total_line_count_f0`  out  LINE_WIDTH  active derived value.

## Operation
- Bank: writes take effect at the clock edge and are accepted in every state. Reset clears all fields to 0.
- FSM states: IDLE → S1 → S2 → S3 → PENDING → IDLE.
- On acceptance, all fields of `calc_mode` are snapshotted. Bank writes issued afterwards do not affect the in-flight calculation.
- S1: `v_active = line_count_f0 + (il ? line_count_f1 : 0)`; `f1_v_start = v1_rising_edge − ap_line`; `h_total_minus_one = sample_count_f0 + h_blank − 1`; `h_sync_end = h_front_porch + h_sync_length`.
- S2: `f2_v_start = v_active + (il ? v1_blank : 0)`; `f1_v_end = f1_v_start + v1_blank`; `total_line_count_f0 = (line_count_f0 + v_blank − v_front_porch + v1_front_porch − 1)[LINE_WIDTH−1:0]`.
- S3: `v_total = f2_v_start + v_blank`; `v_total_minus_one = v_total − 1`; `ap_line_end = v_total − ap_line`; shadow set loaded.
- PENDING: waits for `frame_start`. On it, shadow is copied to active, `mode_changed` pulses, and the FSM returns to IDLE.
- All arithmetic is modulo 2^WIDTH. Underflow wraps with no error, except where the range check applies.
- `h_sync_start` = snapshotted `h_front_porch`; `interlaced` = snapshotted flag (both via shadow).

## Timing
- Request accepted at edge T. S1/S2/S3 occupy cycles T+1..T+3. PENDING is entered at T+4 with the shadow set valid.
- `frame_start` sampled high in PENDING at cycle P: active outputs and `mode_changed` are updated/asserted at P+1, and `calc_ready` is high at P+1.
- `frame_start` in any state other than PENDING is ignored, including the cycle the FSM enters PENDING.
- `calc_req` while not IDLE is ignored (not queued).
- Reset values: all active outputs 0, `interlaced` 0, `mode_changed` 0, `calc_error` 0, `calc_ready` 1, FSM IDLE.
- `rst` mid-calculation or mid-PENDING discards the shadow set. Active outputs go to 0.

## Configuration
- `IS2VID_MODE_RANGE_CHECK_EN` defined:
  - In S3, the mode is rejected if `sample_count_f0 == 0` or the full-precision (WIDTH+1) `v_total` carries out.
  - On rejection the FSM returns to IDLE at T+4 without entering PENDING, the active set is unchanged, and `calc_error` is set.
  - `calc_error` clears on the next accepted request.
- Undefined: no check is performed; `calc_error` is tied 0 and values wrap.

## Test plan
- 1080p descriptor: sample 1920, h_blank 280, h_fp 88, h_sync 44, line_f0 1080, v_blank 45, ap_line 42, il 0, others 0; request + `frame_start` → h_total_minus_one 2199, h_sync_end 132, v_total_minus_one 1124, f2_v_start 1080, ap_line_end 1083; `mode_changed` one cycle.
- 1080i descriptor: line_f0/f1 540, v_blank 22, v1_blank 23, v_fp 2, v1_fp 2, ap_line 21, v1_rising_edge 563, il 1 → f1_v_start 542, f1_v_end 565, f2_v_start 1103, v_total_minus_one 1124, total_line_count_f0 561.
- Commit gating: complete a calculation with `frame_start` withheld 100 cycles → active outputs unchanged and `calc_ready` 0 throughout; change at P+1 only.
- Snapshot isolation: write mode 1 `h_blank`=0 at T+1 during its calculation → result uses the old value; recalculation uses 0.
- Reset in S2 → all outputs 0, `calc_ready` 1; a subsequent `frame_start` causes no `mode_changed`.
- With `IS2VID_MODE_RANGE_CHECK_EN`: line_f0 0xFFF0, v_blank 0x20 → `calc_error` 1, active set unchanged, no `mode_changed`. Without the macro: v_total_minus_one 0x000F.

Source files
------------

// File: rtl/alt_vipitc131_is2vid_mode_sequencer_if.sv
// Bus bundle for the IS2Vid mode sequencer: bank writes, calc request, frame strobe, derived timing outputs.
// master drives writes/requests/frame_start; slave (the sequencer) drives status and active timing values.
// Widths follow NUM_MODES / WIDTH / LINE_WIDTH; mode index width is derived from NUM_MODES.
interface alt_vipitc131_is2vid_mode_sequencer_if #(
  parameter int NUM_MODES  = 4,
  parameter int WIDTH      = 16,
  parameter int LINE_WIDTH = 13
);
  localparam int MODE_W = $clog2(NUM_MODES);

  logic                  wr_en;
  logic [MODE_W-1:0]     wr_mode;
  logic [3:0]            wr_field;
  logic [WIDTH-1:0]      wr_data;
  logic                  calc_req;
  logic [MODE_W-1:0]     calc_mode;
  logic                  calc_ready;
  logic                  frame_start;
  logic                  mode_changed;
  logic                  calc_error;
  logic                  interlaced;
  logic [WIDTH-1:0]      h_total_minus_one;
  logic [WIDTH-1:0]      v_total_minus_one;
  logic [WIDTH-1:0]      h_sync_start;
  logic [WIDTH-1:0]      h_sync_end;
  logic [WIDTH-1:0]      ap_line_end;
  logic [WIDTH-1:0]      f1_v_start;
  logic [WIDTH-1:0]      f1_v_end;
  logic [WIDTH-1:0]      f2_v_start;
  logic [LINE_WIDTH-1:0] total_line_count_f0;

  modport master (
    output wr_en, wr_mode, wr_field, wr_data, calc_req, calc_mode, frame_start,
    input  calc_ready, mode_changed, calc_error, interlaced,
           h_total_minus_one, v_total_minus_one, h_sync_start, h_sync_end,
           ap_line_end, f1_v_start, f1_v_end, f2_v_start, total_line_count_f0
  );

  modport slave (
    input  wr_en, wr_mode, wr_field, wr_data, calc_req, calc_mode, frame_start,
    output calc_ready, mode_changed, calc_error, interlaced,
           h_total_minus_one, v_total_minus_one, h_sync_start, h_sync_end,
           ap_line_end, f1_v_start, f1_v_end, f2_v_start, total_line_count_f0
  );
endinterface

// File: rtl/alt_vipitc131_is2vid_mode_sequencer.sv
// Mode bank + 3-stage timing-value calculator with frame-boundary commit of a shadow set to the active outputs.
// Latency: request accepted at T, shadow valid in PENDING from T+4; active update one cycle after frame_start in PENDING.
// Backpressure: calc_ready is high only in IDLE; requests while busy are dropped. Optional range check: IS2VID_MODE_RANGE_CHECK_EN.
module alt_vipitc131_is2vid_mode_sequencer #(
  parameter int NUM_MODES  = 4,
  parameter int WIDTH      = 16,
  parameter int LINE_WIDTH = 13
) (
  input logic clk,
  input logic rst,
  alt_vipitc131_is2vid_mode_sequencer_if.slave bus
);
  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int NF     = 12;  // WIDTH-wide fields; the interlaced flag is kept separately

  localparam int F_SAMPLE  = 0;
  localparam int F_LC0     = 1;
  localparam int F_LC1     = 2;
  localparam int F_HFP     = 3;
  localparam int F_HSYNC   = 4;
  localparam int F_HBLANK  = 5;
  localparam int F_VFP     = 6;
  localparam int F_VBLANK  = 7;
  localparam int F_V1FP    = 8;
  localparam int F_V1BLANK = 9;
  localparam int F_APLINE  = 10;
  localparam int F_V1RE    = 11;
  localparam int F_IL      = 12;

  typedef enum logic [2:0] {IDLE, S1, S2, S3, PENDING} state_t;

  typedef struct packed {
    logic                  il;
    logic [WIDTH-1:0]      h_total_minus_one;
    logic [WIDTH-1:0]      v_total_minus_one;
    logic [WIDTH-1:0]      h_sync_start;
    logic [WIDTH-1:0]      h_sync_end;
    logic [WIDTH-1:0]      ap_line_end;
    logic [WIDTH-1:0]      f1_v_start;
    logic [WIDTH-1:0]      f1_v_end;
    logic [WIDTH-1:0]      f2_v_start;
    logic [LINE_WIDTH-1:0] total_line_count_f0;
  } set_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] bank [NUM_MODES][NF];
  logic             bank_il [NUM_MODES];
  logic [WIDTH-1:0] snap [NF];
  logic             snap_il;

  logic [WIDTH-1:0]      v_active;
  logic [WIDTH-1:0]      f1_v_start_r;
  logic [WIDTH-1:0]      h_total_m1_r;
  logic [WIDTH-1:0]      h_sync_end_r;
  logic [WIDTH-1:0]      f2_v_start_r;
  logic [WIDTH-1:0]      f1_v_end_r;
  logic [LINE_WIDTH-1:0] tlc_r;
  logic [WIDTH-1:0]      v_total;

  set_t shadow, active;
  logic calc_ready_i, load_snap, load_shadow, commit, reject;
  logic mode_changed_r;

`ifdef IS2VID_MODE_RANGE_CHECK_EN
  logic v_carry;
  logic calc_error_r;
  assign {v_carry, v_total} = {1'b0, f2_v_start_r} + {1'b0, snap[F_VBLANK]};
  assign reject = (snap[F_SAMPLE] == '0) || v_carry;
`else
  assign v_total = f2_v_start_r + snap[F_VBLANK];
  assign reject  = 1'b0;
`endif

  // Mode bank: writes land in any state; the interlaced flag keeps only bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        for (int f = 0; f < NF; f++) bank[m][f] <= '0;
        bank_il[m] <= 1'b0;
      end
    end else if (bus.wr_en) begin
      if (bus.wr_field < 4'(NF)) bank[bus.wr_mode][bus.wr_field] <= bus.wr_data;
      else if (bus.wr_field == 4'(F_IL)) bank_il[bus.wr_mode] <= bus.wr_data[0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: fixed S1..S3 walk, then hold in PENDING until a frame boundary
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.calc_req) state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = reject ? IDLE : PENDING;
      PENDING: if (bus.frame_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake and datapath load strobes
  always_comb begin
    calc_ready_i = (state == IDLE);
    load_snap    = (state == IDLE) && bus.calc_req;
    load_shadow  = (state == S3) && !reject;
    commit       = (state == PENDING) && bus.frame_start;
  end

  // Snapshot on acceptance, then the three arithmetic stages work only from the snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NF; f++) snap[f] <= '0;
      snap_il      <= 1'b0;
      v_active     <= '0;
      f1_v_start_r <= '0;
      h_total_m1_r <= '0;
      h_sync_end_r <= '0;
      f2_v_start_r <= '0;
      f1_v_end_r   <= '0;
      tlc_r        <= '0;
    end else begin
      if (load_snap) begin
        for (int f = 0; f < NF; f++) snap[f] <= bank[bus.calc_mode][f];
        snap_il <= bank_il[bus.calc_mode];
      end
      if (state == S1) begin
        v_active     <= snap[F_LC0] + (snap_il ? snap[F_LC1] : '0);
        f1_v_start_r <= snap[F_V1RE] - snap[F_APLINE];
        h_total_m1_r <= snap[F_SAMPLE] + snap[F_HBLANK] - WIDTH'(1);
        h_sync_end_r <= snap[F_HFP] + snap[F_HSYNC];
      end
      if (state == S2) begin
        f2_v_start_r <= v_active + (snap_il ? snap[F_V1BLANK] : '0);
        f1_v_end_r   <= f1_v_start_r + snap[F_V1BLANK];
        tlc_r        <= LINE_WIDTH'(snap[F_LC0] + snap[F_VBLANK] - snap[F_VFP]
                                    + snap[F_V1FP] - WIDTH'(1));
      end
    end
  end

  // Shadow set loaded in S3; copied to the active set only on a frame boundary in PENDING
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow         <= '0;
      active         <= '0;
      mode_changed_r <= 1'b0;
    end else begin
      mode_changed_r <= commit;
      if (load_shadow) begin
        shadow.il                  <= snap_il;
        shadow.h_total_minus_one   <= h_total_m1_r;
        shadow.v_total_minus_one   <= v_total - WIDTH'(1);
        shadow.h_sync_start        <= snap[F_HFP];
        shadow.h_sync_end          <= h_sync_end_r;
        shadow.ap_line_end         <= v_total - snap[F_APLINE];
        shadow.f1_v_start          <= f1_v_start_r;
        shadow.f1_v_end            <= f1_v_end_r;
        shadow.f2_v_start          <= f2_v_start_r;
        shadow.total_line_count_f0 <= tlc_r;
      end
      if (commit) active <= shadow;
    end
  end

`ifdef IS2VID_MODE_RANGE_CHECK_EN
  // Sticky error: set by a rejected mode, cleared by the next accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           calc_error_r <= 1'b0;
    else if (load_snap)                calc_error_r <= 1'b0;
    else if ((state == S3) && reject)  calc_error_r <= 1'b1;
  end
  assign bus.calc_error = calc_error_r;
`else
  assign bus.calc_error = 1'b0;
`endif

  assign bus.calc_ready          = calc_ready_i;
  assign bus.mode_changed        = mode_changed_r;
  assign bus.interlaced          = active.il;
  assign bus.h_total_minus_one   = active.h_total_minus_one;
  assign bus.v_total_minus_one   = active.v_total_minus_one;
  assign bus.h_sync_start        = active.h_sync_start;
  assign bus.h_sync_end          = active.h_sync_end;
  assign bus.ap_line_end         = active.ap_line_end;
  assign bus.f1_v_start          = active.f1_v_start;
  assign bus.f1_v_end            = active.f1_v_end;
  assign bus.f2_v_start          = active.f2_v_start;
  assign bus.total_line_count_f0 = active.total_line_count_f0;
endmodule

// File: tb/tb_alt_vipitc131_is2vid_mode_sequencer.sv
// Bench for the IS2Vid mode sequencer: directed video-mode cases, then randomized traffic.
// A descriptor-level reference model predicts every output each cycle; literal values pin the model.
module tb_alt_vipitc131_is2vid_mode_sequencer;
  localparam int NM = 4;
  localparam int W  = 16;
  localparam int LW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alt_vipitc131_is2vid_mode_sequencer_if #(.NUM_MODES(NM), .WIDTH(W), .LINE_WIDTH(LW)) bus ();

  alt_vipitc131_is2vid_mode_sequencer #(.NUM_MODES(NM), .WIDTH(W), .LINE_WIDTH(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        il;
    logic [15:0] htm1, vtm1, hss, hse, ape, f1vs, f1ve, f2vs;
    logic [12:0] tlc;
  } res_t;
  typedef logic [15:0][15:0] desc_t;  // one raw descriptor, indexed by field number

  // Timing values straight from the mode descriptor
  function automatic res_t calc(input desc_t f);
    res_t r;
    logic [15:0] va, vt, tl;
    r.il   = f[12][0];
    va     = f[1] + (r.il ? f[2] : 16'd0);
    r.f1vs = f[11] - f[10];
    r.htm1 = f[0] + f[5] - 16'd1;
    r.hse  = f[3] + f[4];
    r.hss  = f[3];
    r.f2vs = va + (r.il ? f[9] : 16'd0);
    r.f1ve = r.f1vs + f[9];
    tl     = f[1] + f[7] - f[6] + f[8] - 16'd1;
    r.tlc  = tl[12:0];
    vt     = r.f2vs + f[7];
    r.vtm1 = vt - 16'd1;
    r.ape  = vt - f[10];
    return r;
  endfunction

  function automatic logic out_of_range(input desc_t f);
    res_t r;
    r = calc(f);
    return (f[0] == 16'd0) || ((32'(r.f2vs) + 32'(f[7])) > 32'd65535);
  endfunction

  // Reference model: bank contents, an in-flight request with its age, and the committed set
  desc_t m_bank [NM];
  logic  busy, m_rej, m_mc, m_err;
  int    age;
  res_t  m_pend, m_act;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NM; i++) m_bank[i] <= '0;
      busy <= 1'b0; age <= 0; m_rej <= 1'b0;
      m_mc <= 1'b0; m_err <= 1'b0; m_pend <= '0; m_act <= '0;
    end else begin
      m_mc <= 1'b0;
      if (bus.wr_en) m_bank[bus.wr_mode][bus.wr_field] <= bus.wr_data;
      if (!busy) begin
        if (bus.calc_req) begin
          busy   <= 1'b1;
          age    <= 0;
          m_pend <= calc(m_bank[bus.calc_mode]);
`ifdef IS2VID_MODE_RANGE_CHECK_EN
          m_rej  <= out_of_range(m_bank[bus.calc_mode]);
          m_err  <= 1'b0;
`else
          m_rej  <= 1'b0;
`endif
        end
      end else begin
        if (age < 1000) age <= age + 1;
        if (age == 2 && m_rej) begin
          busy  <= 1'b0;
          m_err <= 1'b1;
        end else if (age >= 3 && bus.frame_start) begin
          busy  <= 1'b0;
          m_act <= m_pend;
          m_mc  <= 1'b1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [159:0] act_v, exp_v;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0; bus.calc_req = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic wr(input int mode, input int field, input int data);
    bus.wr_en = 1'b1; bus.wr_mode = 2'(mode); bus.wr_field = 4'(field); bus.wr_data = 16'(data);
    cyc1();
  endtask

  task automatic req(input int mode);
    bus.calc_req = 1'b1; bus.calc_mode = 2'(mode);
    cyc1();
  endtask

  task automatic load_1080p(input int mode);
    wr(mode, 0, 1920); wr(mode, 5, 280); wr(mode, 3, 88); wr(mode, 4, 44);
    wr(mode, 1, 1080); wr(mode, 7, 45); wr(mode, 10, 42);
  endtask

  // Wait out S1..S3 after req(), then strobe frame_start in PENDING
  task automatic finish_commit();
    repeat (3) cyc1();
    bus.frame_start = 1'b1;
    cyc1();
  endtask

  initial begin
    int rdy_seen, chg_seen;
    bus.wr_en = 0; bus.wr_mode = 0; bus.wr_field = 0; bus.wr_data = 0;
    bus.calc_req = 0; bus.calc_mode = 0; bus.frame_start = 0;

    fork
      forever begin
        @(negedge clk);
        act_v = {bus.calc_ready, bus.mode_changed, bus.calc_error, bus.interlaced,
                 bus.h_total_minus_one, bus.v_total_minus_one, bus.h_sync_start, bus.h_sync_end,
                 bus.ap_line_end, bus.f1_v_start, bus.f1_v_end, bus.f2_v_start,
                 bus.total_line_count_f0};
        exp_v = {!busy, m_mc, m_err, m_act};
        chk("model_cycle", act_v, exp_v);
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", bus.calc_ready, 1);
    chk("reset_htm1", bus.h_total_minus_one, 0);
    chk("reset_mc", bus.mode_changed, 0);
    chk("reset_err", bus.calc_error, 0);

    // 1080p in mode 0
    load_1080p(0);
    req(0);
    chk("busy_ready", bus.calc_ready, 0);
    finish_commit();
    chk("p_mc", bus.mode_changed, 1);
    chk("p_htm1", bus.h_total_minus_one, 2199);
    chk("p_hse", bus.h_sync_end, 132);
    chk("p_hss", bus.h_sync_start, 88);
    chk("p_vtm1", bus.v_total_minus_one, 1124);
    chk("p_f2vs", bus.f2_v_start, 1080);
    chk("p_ape", bus.ap_line_end, 1083);
    cyc1();
    chk("p_mc_pulse", bus.mode_changed, 0);

    // 1080i in mode 2 with frame_start withheld for 100 cycles
    wr(2, 0, 1920); wr(2, 5, 280); wr(2, 1, 540); wr(2, 2, 540); wr(2, 7, 22); wr(2, 9, 23);
    wr(2, 6, 2); wr(2, 8, 2); wr(2, 10, 21); wr(2, 11, 563); wr(2, 12, 1);
    req(2);
    rdy_seen = 0; chg_seen = 0;
    repeat (100) begin
      cyc1();
      if (bus.calc_ready) rdy_seen++;
      if (bus.f2_v_start != 1080 || bus.interlaced || bus.mode_changed) chg_seen++;
    end
    chk("gate_ready", rdy_seen, 0);
    chk("gate_hold", chg_seen, 0);
    bus.frame_start = 1'b1;
    cyc1();
    chk("i_mc", bus.mode_changed, 1);
    chk("i_ready", bus.calc_ready, 1);
    chk("i_f1vs", bus.f1_v_start, 542);
    chk("i_f1ve", bus.f1_v_end, 565);
    chk("i_f2vs", bus.f2_v_start, 1103);
    chk("i_vtm1", bus.v_total_minus_one, 1124);
    chk("i_tlc", bus.total_line_count_f0, 561);
    chk("i_il", bus.interlaced, 1);

    // Snapshot isolation: h_blank cleared while mode 1 is in flight
    load_1080p(1);
    req(1);
    wr(1, 5, 0);
    repeat (2) cyc1();
    bus.frame_start = 1'b1;
    cyc1();
    chk("snap_old", bus.h_total_minus_one, 2199);
    req(1);
    finish_commit();
    chk("snap_new", bus.h_total_minus_one, 1919);

    // Reset while in S2
    req(0);
    cyc1();
    rst = 1'b1;
    #2;
    chk("rst_ready", bus.calc_ready, 1);
    chk("rst_htm1", bus.h_total_minus_one, 0);
    chk("rst_f2vs", bus.f2_v_start, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.frame_start = 1'b1;
    cyc1();
    chk("rst_no_mc", bus.mode_changed, 0);

    // v_total overflow in mode 3
    load_1080p(0);
    req(0);
    finish_commit();
    wr(3, 0, 1920); wr(3, 1, 16'hFFF0); wr(3, 7, 16'h20);
    req(3);
    finish_commit();
`ifdef IS2VID_MODE_RANGE_CHECK_EN
    chk("ovf_err", bus.calc_error, 1);
    chk("ovf_no_mc", bus.mode_changed, 0);
    chk("ovf_hold", bus.v_total_minus_one, 1124);
`else
    chk("ovf_err", bus.calc_error, 0);
    chk("ovf_mc", bus.mode_changed, 1);
    chk("ovf_wrap", bus.v_total_minus_one, 16'h000F);
`endif
    req(0);
    chk("err_clear", bus.calc_error, 0);
    finish_commit();

    // Randomized traffic
    repeat (2000) begin
      @(posedge clk);
      #1;
      rst             = ($urandom_range(0, 599) == 0);
      bus.wr_en       = ($urandom_range(0, 9) < 3);
      bus.wr_mode     = 2'($urandom_range(0, NM - 1));
      bus.wr_field    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0, 1:    bus.wr_data = 16'($urandom);
        2:       bus.wr_data = 16'd0;
        default: bus.wr_data = 16'($urandom_range(1, 2047));
      endcase
      bus.calc_req    = ($urandom_range(0, 3) == 0);
      bus.calc_mode   = 2'($urandom_range(0, NM - 1));
      bus.frame_start = ($urandom_range(0, 6) == 0);
    end
    rst = 1'b0;
    repeat (2) cyc1();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
